// File: rtl/maple_tx_scheduler.sv
// Round-robin frame scheduler for the Maple output path: grants one of four
// requesters, sequences START / byte stream / END, then waits for bus idle and a turnaround gap.
module maple_tx_scheduler #(
   parameter int TURN_TICKS = 16,
   parameter int WD_TICKS   = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        enable,
   input  logic        tick,
   input  logic [3:0]  req,
   input  logic [31:0] req_len,
   input  logic [7:0]  src_data,
   input  logic        src_valid,
   output logic        src_ready,
   output logic [3:0]  grant,
   output logic [3:0]  done,
   output logic        err_timeout,
   output logic        busy,
   output logic [1:0]  port_select,
   output logic        trigger_start,
   output logic        trigger_end,
   output logic [7:0]  fifo_data,
   output logic        fifo_produce,
   input  logic        fifo_ready,
   input  logic        bus_oe,
   input  logic        start_active,
   input  logic        end_active
);

   typedef enum logic [2:0] {
      ST_IDLE, ST_SETUP, ST_START, ST_STREAM, ST_END, ST_DRAIN, ST_TURN, ST_DONE
   } state_t;

   localparam bit          SKIP_TURN = (TURN_TICKS == 0);
   localparam logic [15:0] TURN_LIM  = 16'(TURN_TICKS);
   localparam logic [8:0]  WD_LIM    = 9'(WD_TICKS);

   state_t      state_reg, state_next;
   logic [3:0]  grant_reg, grant_next;
   logic [1:0]  port_reg, port_next;
   logic [1:0]  ptr_reg, ptr_next;
   logic [7:0]  remain_reg, remain_next;
   logic        err_reg, err_next;
   logic [7:0]  wd_reg, wd_next;
   logic [15:0] turn_reg, turn_next;

   // Candidate ports in priority order: pointer+1 first, the last owner last.
   logic [1:0] cand_port [4];
   logic [3:0] cand_req;
   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_cand
         assign cand_port[gi] = ptr_reg + 2'(gi + 1);
         assign cand_req[gi]  = req[cand_port[gi]];
      end
   endgenerate

   logic [1:0] win_port;
   logic       win_valid;
   logic [7:0] win_len;
   always_comb begin
      win_port  = cand_port[0];
      win_valid = |cand_req;
      for (int i = 3; i >= 0; i--) begin
         if (cand_req[i]) win_port = cand_port[i];
      end
      win_len = req_len[{win_port, 3'b000} +: 8];
   end

   logic xfer;
   logic bus_idle;
   logic wd_hit;
   logic turn_hit;
   assign src_ready    = (state_reg == ST_STREAM) && fifo_ready && (remain_reg != 8'd0);
   assign xfer         = src_ready && src_valid;
   assign fifo_produce = xfer;
   assign fifo_data    = src_data;
   assign bus_idle     = !bus_oe && !start_active && !end_active;
   assign wd_hit       = tick && (({1'b0, wd_reg} + 9'd1) == WD_LIM);
   assign turn_hit     = tick && ((turn_reg + 16'd1) == TURN_LIM);

   always_comb begin
      state_next  = state_reg;
      grant_next  = grant_reg;
      port_next   = port_reg;
      ptr_next    = ptr_reg;
      remain_next = remain_reg;
      err_next    = err_reg;
      wd_next     = wd_reg;
      turn_next   = turn_reg;
      case (state_reg)
         ST_IDLE: begin
            if (enable && win_valid) begin
               grant_next  = 4'b0001 << win_port;
               port_next   = win_port;
               remain_next = win_len;
               err_next    = 1'b0;
               state_next  = ST_SETUP;
            end
         end
         ST_SETUP: state_next = ST_START;
         ST_START: state_next = ST_STREAM;
         ST_STREAM: begin
            if (xfer) remain_next = remain_reg - 8'd1;
            // Leave straight after the last byte so END follows it by one cycle.
            if (remain_reg == 8'd0 || (xfer && remain_reg == 8'd1)) state_next = ST_END;
         end
         ST_END: begin
            wd_next    = 8'd0;
            state_next = ST_DRAIN;
         end
         ST_DRAIN: begin
            if (bus_idle) begin
               turn_next  = 16'd0;
               state_next = SKIP_TURN ? ST_DONE : ST_TURN;
            end else if (tick) begin
               wd_next = wd_reg + 8'd1;
               if (wd_hit) begin
                  err_next   = 1'b1;
                  turn_next  = 16'd0;
                  state_next = SKIP_TURN ? ST_DONE : ST_TURN;
               end
            end
         end
         ST_TURN: begin
            if (tick) begin
               turn_next = turn_reg + 16'd1;
               if (turn_hit) state_next = ST_DONE;
            end
         end
         ST_DONE: begin
            ptr_next   = port_reg;
            grant_next = 4'b0000;
            state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg  <= ST_IDLE;
         grant_reg  <= 4'b0000;
         port_reg   <= 2'd0;
         ptr_reg    <= 2'd3;
         remain_reg <= 8'd0;
         err_reg    <= 1'b0;
         wd_reg     <= 8'd0;
         turn_reg   <= 16'd0;
      end else begin
         state_reg  <= state_next;
         grant_reg  <= grant_next;
         port_reg   <= port_next;
         ptr_reg    <= ptr_next;
         remain_reg <= remain_next;
         err_reg    <= err_next;
         wd_reg     <= wd_next;
         turn_reg   <= turn_next;
      end
   end

   assign grant         = grant_reg;
   assign port_select   = port_reg;
   assign err_timeout   = err_reg;
   assign busy          = (state_reg != ST_IDLE);
   assign trigger_start = (state_reg == ST_START);
   assign trigger_end   = (state_reg == ST_END);
   assign done          = (state_reg == ST_DONE) ? grant_reg : 4'b0000;

endmodule
